// File: rtl/regfile_op_sequencer_if.sv
// rtl/regfile_op_sequencer_if.sv - command, register-file, ALU and response bus of the register file sequencer
// Ports: none. Parameter DATA_W is the register and datapath width.
// Modport slave is used by the sequencer and modport master by its environment.
// The groups are: cmd_* command handshake, rf_* register file, alu_* ALU, and rsp_* response plus busy.
interface regfile_op_sequencer_if #(
    parameter int DATA_W = 512
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [2:0]        cmd_dst;
    logic [2:0]        cmd_src1;
    logic [2:0]        cmd_src2;
    logic [1:0]        cmd_fn;
    logic [DATA_W-1:0] cmd_data;

    logic [2:0]        rf_sel_write;
    logic [2:0]        rf_sel_read1;
    logic [2:0]        rf_sel_read2;
    logic              rf_write_enable;
    logic [DATA_W-1:0] rf_data_in;
    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;

    logic              alu_start;
    logic [1:0]        alu_fn;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_done;
    logic [DATA_W-1:0] alu_result;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_fn, cmd_data,
        output cmd_ready,
        output rf_sel_write, rf_sel_read1, rf_sel_read2, rf_write_enable, rf_data_in,
        input  rf_rd1, rf_rd2,
        output alu_start, alu_fn, alu_a, alu_b,
        input  alu_done, alu_result,
        output rsp_valid, rsp_data, rsp_err, busy,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_fn, cmd_data,
        input  cmd_ready,
        input  rf_sel_write, rf_sel_read1, rf_sel_read2, rf_write_enable, rf_data_in,
        output rf_rd1, rf_rd2,
        input  alu_start, alu_fn, alu_a, alu_b,
        output alu_done, alu_result,
        input  rsp_valid, rsp_data, rsp_err, busy,
        output rsp_ready
    );
endinterface

// File: rtl/regfile_op_sequencer.sv
// rtl/regfile_op_sequencer.sv - serial LOAD/READ/MOVE/ALU sequencer for a small wide register file
// Ports: clk is the rising-edge clock. rst_n is a synchronous active-low reset.
// bus (slave) carries the command handshake, the register file selects/write/read data,
// the ALU start/done handshake with operands, and the response handshake plus busy.
module regfile_op_sequencer #(
    parameter int DATA_W      = 512,
    parameter int NUM_REGS    = 4,
    parameter int ALU_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_op_sequencer_if.slave  bus
);
    localparam int                CNT_W    = $clog2(ALU_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);
    localparam logic [3:0]        NREGS    = 4'(NUM_REGS);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_READ = 2'b01;
    localparam logic [1:0] OP_MOVE = 2'b10;
    localparam logic [1:0] OP_ALU  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_START,
        S_ALU_WAIT,
        S_WRITE,
        S_RESP
    } state_t;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [2:0]         r_dst;
    logic [2:0]         r_src1;
    logic [2:0]         r_src2;
    logic [1:0]         r_fn;
    logic [DATA_W-1:0]  r_data;
    logic [DATA_W-1:0]  r_result;
    logic [DATA_W-1:0]  r_alu_a;
    logic [DATA_W-1:0]  r_alu_b;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;

    logic               w_bad_dst;
    logic               w_bad_src1;
    logic               w_bad_src2;
    logic               w_idx_err;
    logic [DATA_W-1:0]  w_wdata;

    assign w_bad_dst  = {1'b0, bus.cmd_dst}  >= NREGS;
    assign w_bad_src1 = {1'b0, bus.cmd_src1} >= NREGS;
    assign w_bad_src2 = {1'b0, bus.cmd_src2} >= NREGS;

    // Only the indices the opcode actually uses are range-checked.
    always_comb begin
        w_idx_err = 1'b0;
        case (bus.cmd_op)
            OP_LOAD: w_idx_err = w_bad_dst;
            OP_READ: w_idx_err = w_bad_src1;
            OP_MOVE: w_idx_err = w_bad_dst | w_bad_src1;
            default: w_idx_err = w_bad_dst | w_bad_src1 | w_bad_src2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_dst    <= '0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_fn     <= '0;
            r_data   <= '0;
            r_result <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // cmd_ready is high whenever IDLE is reached out of reset
                    if (bus.cmd_valid) begin
                        r_op     <= bus.cmd_op;
                        r_dst    <= bus.cmd_dst;
                        r_src1   <= bus.cmd_src1;
                        r_src2   <= bus.cmd_src2;
                        r_fn     <= bus.cmd_fn;
                        r_data   <= bus.cmd_data;
                        r_result <= '0;
                        r_err    <= w_idx_err;
                        if (w_idx_err)
                            r_state <= S_RESP;
                        else if (bus.cmd_op == OP_LOAD)
                            r_state <= S_WRITE;
                        else
                            r_state <= S_RD;
                    end
                end
                S_RD: begin
                    r_result <= bus.rf_rd1;
                    if (r_op == OP_ALU) begin
                        r_alu_a <= bus.rf_rd1;
                        r_alu_b <= bus.rf_rd2;
                        r_state <= S_START;
                    end else if (r_op == OP_MOVE) begin
                        r_state <= S_WRITE;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= S_ALU_WAIT;
                end
                S_ALU_WAIT: begin
                    // done takes priority over a timeout landing in the same cycle
                    if (bus.alu_done) begin
                        r_result <= bus.alu_result;
                        r_state  <= S_WRITE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A failed LOAD reports zero data, like any other index error.
    assign w_wdata = (r_op == OP_LOAD && !r_err) ? r_data : r_result;

    // Every output is qualified by rst_n so the block is silent for the whole reset window.
    assign bus.cmd_ready       = rst_n && (r_state == S_IDLE);
    assign bus.busy            = rst_n && (r_state != S_IDLE);
    assign bus.rf_sel_read1    = (rst_n && r_state == S_RD) ? r_src1 : 3'd0;
    assign bus.rf_sel_read2    = (rst_n && r_state == S_RD && r_op == OP_ALU) ? r_src2 : 3'd0;
    assign bus.rf_sel_write    = (rst_n && r_state == S_WRITE) ? r_dst : 3'd0;
    assign bus.rf_write_enable = rst_n && (r_state == S_WRITE);
    assign bus.rf_data_in      = (rst_n && r_state == S_WRITE) ? w_wdata : '0;
    assign bus.alu_start       = rst_n && (r_state == S_START);
    assign bus.alu_fn          = (rst_n && r_state == S_START) ? r_fn : 2'd0;
    assign bus.alu_a           = rst_n ? r_alu_a : '0;
    assign bus.alu_b           = rst_n ? r_alu_b : '0;
    assign bus.rsp_valid       = rst_n && (r_state == S_RESP);
    assign bus.rsp_err         = rst_n && (r_state == S_RESP) && r_err;
    assign bus.rsp_data        = (rst_n && r_state == S_RESP) ? w_wdata : '0;
endmodule

// File: tb/tb_regfile_op_sequencer.sv
// tb/tb_regfile_op_sequencer.sv - directed self-checking bench for regfile_op_sequencer
module tb_regfile_op_sequencer;
    localparam int DW = 512;
    localparam logic [DW-1:0] V5  = DW'(5);
    localparam logic [DW-1:0] V7  = DW'(7);
    localparam logic [DW-1:0] V12 = DW'(12);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [DW-1:0] pat;
    logic [DW-1:0] regs [4];

    always #5 clk = ~clk;

    regfile_op_sequencer_if #(.DATA_W(DW)) bus ();

    regfile_op_sequencer #(.DATA_W(DW), .NUM_REGS(4), .ALU_TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always_ff @(posedge clk) begin
        if (bus.rf_write_enable) regs[bus.rf_sel_write[1:0]] <= bus.rf_data_in;
    end
    assign bus.rf_rd1 = (bus.rf_sel_read1 < 3'd4) ? regs[bus.rf_sel_read1[1:0]] : '0;
    assign bus.rf_rd2 = (bus.rf_sel_read2 < 3'd4) ? regs[bus.rf_sel_read2[1:0]] : '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller one cycle after the accept edge (cycle 1).
    task automatic send_cmd(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] s1,
                            input logic [2:0] s2, input logic [1:0] fn, input logic [DW-1:0] data);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_accept_wait: cmd_ready=%b want 1", bus.cmd_ready); end
        bus.cmd_op = op; bus.cmd_dst = dst; bus.cmd_src1 = s1; bus.cmd_src2 = s2;
        bus.cmd_fn = fn; bus.cmd_data = data; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic ack_rsp();
        int n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_wait: rsp_valid=%b want 1", bus.rsp_valid); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b want 0", bus.cmd_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rf_write_enable !== 1'b0 || bus.alu_start !== 1'b0) begin errors++; $display("FAIL rst_strobes: we=%b start=%b want 0 0", bus.rf_write_enable, bus.alu_start); end
        checks++; if (bus.alu_a !== '0) begin errors++; $display("FAIL rst_alu_a: got %h want 0", bus.alu_a); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_release: cmd_ready=%b busy=%b want 1 0", bus.cmd_ready, bus.busy); end
    endtask

    task automatic test_load();
        send_cmd(2'b00, 3'd2, 3'd0, 3'd0, 2'd0, pat);
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_sel_write !== 3'd2) begin errors++; $display("FAIL load_write: we=%b sel=%0d want 1 2", bus.rf_write_enable, bus.rf_sel_write); end
        checks++; if (bus.rf_data_in !== pat) begin errors++; $display("FAIL load_data_in: got %h want %h", bus.rf_data_in, pat); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL load_early_rsp: got %b want 0", bus.rsp_valid); end
        tick();
        checks++; if (bus.rf_write_enable !== 1'b0) begin errors++; $display("FAIL load_we_once: got %b want 0", bus.rf_write_enable); end
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL load_rsp: valid=%b err=%b want 1 0", bus.rsp_valid, bus.rsp_err); end
        checks++; if (bus.rsp_data !== pat) begin errors++; $display("FAIL load_rsp_data: got %h want %h", bus.rsp_data, pat); end
        ack_rsp();
        checks++; if (regs[2] !== pat) begin errors++; $display("FAIL load_reg2: got %h want %h", regs[2], pat); end
        send_cmd(2'b00, 3'd1, 3'd0, 3'd0, 2'd0, V5); ack_rsp();
        send_cmd(2'b00, 3'd3, 3'd0, 3'd0, 2'd0, V7); ack_rsp();
        checks++; if (regs[1] !== V5 || regs[3] !== V7) begin errors++; $display("FAIL load_r1_r3: got %0d %0d want 5 7", regs[1], regs[3]); end
    endtask

    task automatic test_alu();
        int starts = 0;
        send_cmd(2'b11, 3'd0, 3'd1, 3'd3, 2'd0, '0);
        checks++; if (bus.rf_sel_read1 !== 3'd1 || bus.rf_sel_read2 !== 3'd3) begin errors++; $display("FAIL alu_rd_sel: got %0d %0d want 1 3", bus.rf_sel_read1, bus.rf_sel_read2); end
        tick();
        checks++; if (bus.alu_start !== 1'b1 || bus.alu_fn !== 2'd0) begin errors++; $display("FAIL alu_start: start=%b fn=%0d want 1 0", bus.alu_start, bus.alu_fn); end
        checks++; if (bus.alu_a !== V5 || bus.alu_b !== V7) begin errors++; $display("FAIL alu_operands: a=%0d b=%0d want 5 7", bus.alu_a, bus.alu_b); end
        for (int c = 3; c <= 6; c++) begin tick(); if (bus.alu_start === 1'b1) starts++; end
        bus.alu_done = 1'b1; bus.alu_result = V5 + V7;
        checks++; if (starts != 0) begin errors++; $display("FAIL alu_start_pulse: extra pulses=%0d want 0", starts); end
        tick();
        bus.alu_done = 1'b0;
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_sel_write !== 3'd0 || bus.rf_data_in !== V12) begin errors++; $display("FAIL alu_write: we=%b sel=%0d data=%0d want 1 0 12", bus.rf_write_enable, bus.rf_sel_write, bus.rf_data_in); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL alu_early_rsp: got %b want 0", bus.rsp_valid); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_data !== V12) begin errors++; $display("FAIL alu_rsp: valid=%b err=%b data=%0d want 1 0 12", bus.rsp_valid, bus.rsp_err, bus.rsp_data); end
        ack_rsp();
        checks++; if (regs[0] !== V12) begin errors++; $display("FAIL alu_reg0: got %0d want 12", regs[0]); end
    endtask

    task automatic test_illegal();
        send_cmd(2'b01, 3'd0, 3'd6, 3'd0, 2'd0, '0);
        checks++; if (bus.rf_write_enable !== 1'b0) begin errors++; $display("FAIL illegal_we: got %b want 0", bus.rf_write_enable); end
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== '0) begin errors++; $display("FAIL illegal_rsp: valid=%b err=%b data=%h want 1 1 0", bus.rsp_valid, bus.rsp_err, bus.rsp_data); end
        ack_rsp();
        send_cmd(2'b01, 3'd0, 3'd1, 3'd0, 2'd0, '0);
        checks++; if (bus.rf_sel_read1 !== 3'd1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL read_rd: sel=%0d valid=%b want 1 0", bus.rf_sel_read1, bus.rsp_valid); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_data !== V5) begin errors++; $display("FAIL read_rsp: valid=%b err=%b data=%0d want 1 0 5", bus.rsp_valid, bus.rsp_err, bus.rsp_data); end
        ack_rsp();
    endtask

    task automatic test_timeout();
        int we_seen = 0;
        int early = 0;
        send_cmd(2'b11, 3'd2, 3'd1, 3'd3, 2'd1, '0);
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) tick();
            if (bus.rf_write_enable === 1'b1) we_seen++;
            if (bus.rsp_valid === 1'b1) early++;
        end
        tick();
        checks++; if (we_seen != 0 || early != 0) begin errors++; $display("FAIL timeout_quiet: writes=%0d early_rsp=%0d want 0 0", we_seen, early); end
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1) begin errors++; $display("FAIL timeout_rsp: valid=%b err=%b want 1 1", bus.rsp_valid, bus.rsp_err); end
        ack_rsp();
        checks++; if (regs[2] !== pat) begin errors++; $display("FAIL timeout_reg2: got %h want %h", regs[2], pat); end
    endtask

    task automatic test_done_last();
        send_cmd(2'b11, 3'd2, 3'd1, 3'd3, 2'd2, '0);
        tick();
        checks++; if (bus.alu_fn !== 2'd2) begin errors++; $display("FAIL done_last_fn: got %0d want 2", bus.alu_fn); end
        for (int c = 3; c <= 10; c++) tick();
        bus.alu_done = 1'b1; bus.alu_result = V12;
        tick();
        bus.alu_done = 1'b0;
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_sel_write !== 3'd2 || bus.rf_data_in !== V12) begin errors++; $display("FAIL done_last_write: we=%b sel=%0d data=%0d want 1 2 12", bus.rf_write_enable, bus.rf_sel_write, bus.rf_data_in); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_data !== V12) begin errors++; $display("FAIL done_last_rsp: valid=%b err=%b data=%0d want 1 0 12", bus.rsp_valid, bus.rsp_err, bus.rsp_data); end
        ack_rsp();
    endtask

    task automatic test_move_stall();
        int stable = 0;
        send_cmd(2'b10, 3'd1, 3'd1, 3'd0, 2'd0, '0);
        checks++; if (bus.rf_sel_read1 !== 3'd1) begin errors++; $display("FAIL move_rd: got %0d want 1", bus.rf_sel_read1); end
        tick();
        checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_sel_write !== 3'd1 || bus.rf_data_in !== V5) begin errors++; $display("FAIL move_write: we=%b sel=%0d data=%0d want 1 1 5", bus.rf_write_enable, bus.rf_sel_write, bus.rf_data_in); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.rsp_valid === 1'b1 && bus.rsp_data === V5 && bus.rsp_err === 1'b0 && bus.cmd_ready === 1'b0) stable++;
        end
        checks++; if (stable != 5) begin errors++; $display("FAIL move_stall_stable: got %0d cycles want 5", stable); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL move_idle: valid=%b ready=%b busy=%b want 0 1 0", bus.rsp_valid, bus.cmd_ready, bus.busy); end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        send_cmd(2'b11, 3'd0, 3'd1, 3'd3, 2'd0, '0);
        tick(); tick(); tick();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b want 1", bus.busy); end
        rst_n = 1'b0;
        tick();
        checks++; if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.alu_start !== 1'b0) begin errors++; $display("FAIL midrst_outputs: ready=%b busy=%b valid=%b start=%b want 0 0 0 0", bus.cmd_ready, bus.busy, bus.rsp_valid, bus.alu_start); end
        checks++; if (bus.alu_a !== '0 || bus.alu_b !== '0) begin errors++; $display("FAIL midrst_operands: a=%0d b=%0d want 0 0", bus.alu_a, bus.alu_b); end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.rf_write_enable === 1'b1 || bus.rsp_valid === 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL midrst_quiet: events=%0d want 0", bad); end
        checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.alu_a !== '0) begin errors++; $display("FAIL midrst_idle: ready=%b busy=%b a=%0d want 1 0 0", bus.cmd_ready, bus.busy, bus.alu_a); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        pat = {64{8'hA5}};
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_dst = '0; bus.cmd_src1 = '0;
        bus.cmd_src2 = '0; bus.cmd_fn = '0; bus.cmd_data = '0;
        bus.alu_done = 1'b0; bus.alu_result = '0; bus.rsp_ready = 1'b0;
        test_reset();
        test_load();
        test_alu();
        test_illegal();
        test_timeout();
        test_done_last();
        test_move_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Command-driven controller that sequences the 4 x 512-bit register file: LOAD, READ, MOVE and two-operand ALU operations.
- Accepts one command at a time through a valid/ready handshake.
- Drives the register file's write/read selects, write enable and write data.
- Hands operands to an external 512-bit ALU over a start/done handshake, writes the result back, and returns a response.

Parameters:
- DATA_W, 512, register and datapath width.
- NUM_REGS, 4, number of implemented registers; valid indices are 0..NUM_REGS-1.
- ALU_TIMEOUT, 64, maximum cycles spent in ALU_WAIT before the command is aborted with an error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00=LOAD, 01=READ, 10=MOVE, 11=ALU.
- cmd_dst  in  3  destination register index.
- cmd_src1  in  3  source 1 index.
- cmd_src2  in  3  source 2 index (ALU only).
- cmd_fn  in  2  ALU function code, passed through to the ALU.
- cmd_data  in  DATA_W  LOAD data.
- rf_sel_write  out  3  register file write select.
- rf_sel_read1  out  3  register file read port 1 select.
- rf_sel_read2  out  3  register file read port 2 select.
- rf_write_enable  out  1  register file write strobe.
- rf_data_in  out  DATA_W  register file write data.
- rf_rd1  in  DATA_W  register file read port 1 data (combinational).
- rf_rd2  in  DATA_W  register file read port 2 data (combinational).
- alu_start  out  1  one-cycle start pulse.
- alu_fn  out  2  latched function code.
- alu_a  out  DATA_W  operand A (registered).
- alu_b  out  DATA_W  operand B (registered).
- alu_done  in  1  ALU result valid.
- alu_result  in  DATA_W  ALU result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DATA_W  READ/MOVE/ALU result, or the LOAD data.
- rsp_err  out  1  command aborted: illegal index or ALU timeout.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: rst_n sampled on the rising edge of clk.
  - State goes to IDLE.
  - All outputs are 0 while rst_n is low, including cmd_ready.
  - Latched command, result and timeout counter are cleared.
  - Reset asserted mid-command aborts it: no write, no response.
- Outputs are Moore, decoded from state plus latched fields only. No output depends combinationally on cmd_* or alu_*.
- Selects not in use are driven to 0. rf_write_enable is high only in WRITE.
- IDLE: cmd_ready=1. A command is accepted when cmd_valid and cmd_ready are both high; all cmd_* fields are latched.
  - Index check: any used index >= NUM_REGS sends the FSM to RESP with rsp_err=1, rsp_data=0, and no register write.
  - LOAD checks dst. READ checks src1. MOVE checks dst and src1. ALU checks dst, src1 and src2.
  - Otherwise: LOAD goes to WRITE; READ, MOVE and ALU go to RD.
- RD, 1 cycle: rf_sel_read1=src1 and rf_sel_read2=src2.
  - rf_rd1 is captured into the result register.
  - For ALU, rf_rd1 and rf_rd2 are also captured into alu_a and alu_b.
  - Next state: READ goes to RESP, MOVE goes to WRITE, ALU goes to START.
- START, 1 cycle: alu_start=1 and alu_fn=latched fn. Next state is ALU_WAIT with the counter cleared. alu_done is ignored in this cycle.
- ALU_WAIT:
  - alu_done=1: capture alu_result into the result register and go to WRITE.
  - Otherwise the counter increments each cycle. When the counter reaches ALU_TIMEOUT-1 without done, go to RESP with rsp_err=1 and no write.
  - done and timeout in the same cycle: done wins.
- WRITE, 1 cycle: rf_write_enable=1 and rf_sel_write=dst. rf_data_in is cmd_data for LOAD, otherwise the result register. Next state is RESP.
- RESP: rsp_valid=1, holding rsp_data and rsp_err stable until rsp_ready=1, then IDLE.
  - rsp_data is cmd_data for LOAD, otherwise the result register.
  - cmd_ready=0 in every state except IDLE. Back-to-back throughput is therefore one command per response plus one IDLE cycle.
- Latency, with the accept edge as cycle 0 and rsp_valid at:
  - LOAD: cycle 2.
  - READ: cycle 2.
  - MOVE: cycle 3.
  - ALU: cycle d+2, where d is the cycle in which done is sampled (d >= 3).
- MOVE or ALU with dst equal to a source reads the old value and writes the new one; there is no hazard because operations are strictly serial.

Test Plan:
- Reset, then LOAD dst=2 with data=0xA5..A5 (512-bit) → rf_write_enable for exactly 1 cycle at cycle 1 with rf_sel_write=2; rsp_valid at cycle 2 with rsp_data=0xA5..A5 and rsp_err=0.
- Register model holds R1=5 and R3=7; ALU fn=00, src1=1, src2=3, dst=0; ALU model returns the sum 4 cycles after start → alu_a=5, alu_b=7, alu_start is a single pulse, write of 12 to R0, rsp_data=12.
- READ src1=6 (illegal) → no rf_write_enable, rsp_err=1, rsp_data=0; a following READ src1=1 returns 5 normally.
- ALU with alu_done never asserted, ALU_TIMEOUT=8 → rsp_err=1 after 8 wait cycles and no write; alu_done arriving exactly on the last wait cycle → normal writeback instead.
- MOVE src1=1 to dst=1, and rsp_ready held low for 5 cycles → rsp_valid and rsp_data stay stable for 5 cycles, cmd_ready=0 throughout, and IDLE returns one cycle after rsp_ready.
- rst_n pulled low during ALU_WAIT → next cycle all outputs are 0, no write occurs, no response is issued, and the state is IDLE once rst_n is released.
